// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC read sequencer: FSM states, field indices, RTC register map.
// Also holds the BCD validity helper used when the RTC_SEQ_BCD_CHECK_EN build is selected.
package rtc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    READ  = 3'd2,
    RECOV = 3'd3,
    LATCH = 3'd4
  } state_t;

  localparam int N_FIELDS = 6;

  localparam logic [2:0] F_SEC   = 3'd0;
  localparam logic [2:0] F_MIN   = 3'd1;
  localparam logic [2:0] F_HOUR  = 3'd2;
  localparam logic [2:0] F_DATE  = 3'd3;
  localparam logic [2:0] F_MONTH = 3'd4;
  localparam logic [2:0] F_YEAR  = 3'd5;

  // RTC register addresses, indexed by field number.
  localparam logic [7:0] ADDR_TABLE [N_FIELDS] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};

  function automatic logic is_bcd(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_read_sequencer_if.sv
// Bus bundle between the sequencer (master) and its environment: RTC A/D bus plus field-register outputs.
// master = sequencer side, slave = RTC/display side.
interface rtc_read_sequencer_if;
  logic       start;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       ale;
  logic [7:0] dseg;
  logic [5:0] en_deco;
  logic       act;
  logic       busy;
  logic       done;
  logic       bcd_err;

  modport master (
    input  start, ad_in,
    output ad_out, ad_oe, cs_n, rd_n, ale, dseg, en_deco, act, busy, done, bcd_err
  );

  modport slave (
    output start, ad_in,
    input  ad_out, ad_oe, cs_n, rd_n, ale, dseg, en_deco, act, busy, done, bcd_err
  );
endinterface

// File: rtl/rtc_bus_phase_timer.sv
// Loadable down-counter timing one bus phase; phase_last flags the final cycle of a T_PH-cycle phase.
// Load takes effect next cycle (count = T_PH-1); no backpressure.
module rtc_bus_phase_timer #(
  parameter int T_PH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  output logic o_phase_last
);

  localparam int W = (T_PH > 1) ? $clog2(T_PH) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(T_PH - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_phase_last = (r_cnt == '0);

endmodule

// File: rtl/rtc_read_sequencer.sv
// Reads the six RTC time/date bytes over the muxed A/D bus and strobes each into its field register (optional RTC_SEQ_BCD_CHECK_EN).
// Latency 3*T_PH+1 cycles per field, 6 fields per frame; no backpressure, start ignored while busy.
module rtc_read_sequencer
  import rtc_pkg::*;
#(
  parameter int T_PH = 4
) (
  input logic                  clk,
  input logic                  reset,
  rtc_read_sequencer_if.master bus
);

  state_t     r_state;
  logic [2:0] r_idx;
  logic [7:0] r_dseg;
  logic [7:0] r_ad_out;
  logic [5:0] r_en_deco;
  logic       r_act;
  logic       r_done;
  logic       r_bcd_err;
  logic       r_cs_n;
  logic       r_rd_n;
  logic       r_ale;
  logic       r_ad_oe;
  logic       r_busy;

  logic       w_in_phase;
  logic       w_phase_last;
  logic       w_load;
  logic       w_deliver;
  logic [2:0] w_idx_nxt;

  assign w_in_phase = (r_state == ADDR) || (r_state == READ) || (r_state == RECOV);
  // Timer reloads on every phase boundary and idles loaded outside the timed phases.
  assign w_load     = !w_in_phase || w_phase_last;
  assign w_idx_nxt  = r_idx + 3'd1;

`ifdef RTC_SEQ_BCD_CHECK_EN
  assign w_deliver = is_bcd(r_dseg);
`else
  assign w_deliver = 1'b1;
`endif

  rtc_bus_phase_timer #(.T_PH(T_PH)) u_timer (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .o_phase_last (w_phase_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= F_SEC;
      r_dseg    <= 8'h00;
      r_ad_out  <= 8'h00;
      r_en_deco <= 6'h00;
      r_act     <= 1'b0;
      r_done    <= 1'b0;
      r_bcd_err <= 1'b0;
      r_cs_n    <= 1'b1;
      r_rd_n    <= 1'b1;
      r_ale     <= 1'b0;
      r_ad_oe   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_act     <= 1'b0;
      r_en_deco <= 6'h00;
      r_done    <= 1'b0;
      r_bcd_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state  <= ADDR;
            r_idx    <= F_SEC;
            r_busy   <= 1'b1;
            r_cs_n   <= 1'b0;
            r_ale    <= 1'b1;
            r_ad_oe  <= 1'b1;
            r_ad_out <= ADDR_TABLE[F_SEC];
          end
        end
        ADDR: begin
          if (w_phase_last) begin
            r_state  <= READ;
            r_ale    <= 1'b0;
            r_ad_oe  <= 1'b0;
            r_ad_out <= 8'h00;
            r_rd_n   <= 1'b0;
          end
        end
        READ: begin
          if (w_phase_last) begin
            r_state <= RECOV;
            r_dseg  <= bus.ad_in;
            r_cs_n  <= 1'b1;
            r_rd_n  <= 1'b1;
          end
        end
        RECOV: begin
          // Outputs for LATCH are decided here so they are registered on entry.
          if (w_phase_last) begin
            r_state   <= LATCH;
            r_act     <= w_deliver;
            r_en_deco <= w_deliver ? (6'b000001 << r_idx) : 6'h00;
            r_done    <= (r_idx == F_YEAR);
            r_bcd_err <= !w_deliver;
          end
        end
        LATCH: begin
          if (r_idx == F_YEAR) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state  <= ADDR;
            r_idx    <= w_idx_nxt;
            r_cs_n   <= 1'b0;
            r_ale    <= 1'b1;
            r_ad_oe  <= 1'b1;
            r_ad_out <= ADDR_TABLE[w_idx_nxt];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ad_out  = r_ad_out;
  assign bus.ad_oe   = r_ad_oe;
  assign bus.cs_n    = r_cs_n;
  assign bus.rd_n    = r_rd_n;
  assign bus.ale     = r_ale;
  assign bus.dseg    = r_dseg;
  assign bus.en_deco = r_en_deco;
  assign bus.act     = r_act;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bcd_err = r_bcd_err;

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// Directed + randomized bench for rtc_read_sequencer at T_PH=4 and T_PH=1, with an RTC bus model and event-level reference model.
module tb_rtc_read_sequencer;

`ifdef RTC_SEQ_BCD_CHECK_EN
  localparam bit BCD_CHK = 1'b1;
`else
  localparam bit BCD_CHK = 1'b0;
`endif

  localparam logic [29:0] RST_OUTS = {4'b1100, 26'd0};

  typedef struct packed {
    logic [31:0] cyc;
    logic        act;
    logic [5:0]  en;
    logic [7:0]  dseg;
    logic        done;
    logic        err;
  } ev_t;

  logic clk = 1'b0;
  logic rst4, rst1;
  always #5 clk = ~clk;

  rtc_read_sequencer_if b4 ();
  rtc_read_sequencer_if b1 ();

  rtc_read_sequencer #(.T_PH(4)) u4 (.clk(clk), .reset(rst4), .bus(b4));
  rtc_read_sequencer #(.T_PH(1)) u1 (.clk(clk), .reset(rst1), .bus(b1));

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  ev_t  q4[$], q1[$], exp_q[$];
  int   rise4[$], fall4[$];
  logic [7:0] aq4[$];
  int   viol4 = 0, unstable4 = 0;
  logic [7:0] mem4[6], mem1[6];
  logic [7:0] lat4 = 8'h21, lat1 = 8'h21, pa4 = 8'h00;
  logic pb4 = 1'b0, pale4 = 1'b0;

  logic [29:0] w_o4, w_o1;
  assign w_o4 = {b4.cs_n, b4.rd_n, b4.ale, b4.ad_oe, b4.ad_out, b4.dseg, b4.en_deco,
                 b4.act, b4.busy, b4.done, b4.bcd_err};
  assign w_o1 = {b1.cs_n, b1.rd_n, b1.ale, b1.ad_oe, b1.ad_out, b1.dseg, b1.en_deco,
                 b1.act, b1.busy, b1.done, b1.bcd_err};

  always @(posedge clk) cyc++;

  function automatic logic [7:0] rd(input logic [7:0] m[6], input logic [7:0] a);
    int i;
    i = int'(a) - 33;
    if (i >= 0 && i < 6) return m[i];
    return 8'hEE;
  endfunction

  // RTC model + monitors, evaluated mid-cycle.
  always @(negedge clk) begin
    if (b4.ale) lat4 = b4.ad_out;
    b4.ad_in = !b4.rd_n ? rd(mem4, lat4) : 8'h00;
    if (b4.ad_oe && !b4.rd_n) viol4++;
    if (b4.ale && !pale4) aq4.push_back(b4.ad_out);
    if (b4.ale && pale4 && b4.ad_out != pa4) unstable4++;
    pale4 = b4.ale;
    pa4   = b4.ad_out;
    if (b4.busy && !pb4) rise4.push_back(cyc);
    if (!b4.busy && pb4) fall4.push_back(cyc);
    pb4 = b4.busy;
    if (b4.act || b4.done || b4.bcd_err)
      q4.push_back('{32'(cyc), b4.act, b4.en_deco, b4.dseg, b4.done, b4.bcd_err});

    if (b1.ale) lat1 = b1.ad_out;
    b1.ad_in = !b1.rd_n ? rd(mem1, lat1) : 8'h00;
    if (b1.act || b1.done || b1.bcd_err)
      q1.push_back('{32'(cyc), b1.act, b1.en_deco, b1.dseg, b1.done, b1.bcd_err});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Reference: each field takes 3T+1 cycles, its strobe falls in the last one.
  task automatic expect_frame(input int t, input int k, input logic [7:0] m[6]);
    ev_t e;
    bit  bad, deliver;
    for (int f = 0; f < 6; f++) begin
      bad     = (m[f][7:4] > 4'd9) || (m[f][3:0] > 4'd9);
      deliver = !(BCD_CHK && bad);
      if (deliver || f == 5 || (BCD_CHK && bad)) begin
        e.cyc  = 32'(k + 3 * t + f * (3 * t + 1));
        e.act  = deliver;
        e.en   = deliver ? 6'(1 << f) : 6'h00;
        e.dseg = m[f];
        e.done = (f == 5);
        e.err  = BCD_CHK && bad;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic cmp_events(input string tag, input bit sel1);
    ev_t got[$];
    if (sel1) begin got = q1; q1.delete(); end
    else begin got = q4; q4.delete(); end
    chk($sformatf("%s event count", tag), 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s event %0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic start_and_wait(input bit sel1, output int k);
    @(negedge clk);
    if (sel1) b1.start = 1'b1; else b4.start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    b1.start = 1'b0;
    b4.start = 1'b0;
    for (int n = 0; n < 300 && (sel1 ? b1.busy : b4.busy); n++) @(negedge clk);
    chk("frame completes", 64'(sel1 ? b1.busy : b4.busy), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [7:0] rnd_byte();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2;
    rst4 = 1'b1;
    rst1 = 1'b1;
    b4.start = 1'b0;
    b1.start = 1'b0;
    for (int i = 0; i < 6; i++) begin mem4[i] = 8'h00; mem1[i] = 8'h00; end
    repeat (3) @(posedge clk);
    #1;
    rst4 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    chk("reset outputs T4", 64'(w_o4), 64'(RST_OUTS));
    chk("reset outputs T1", 64'(w_o1), 64'(RST_OUTS));
    q4.delete(); q1.delete(); aq4.delete(); rise4.delete(); fall4.delete();

    // Directed frame with a realistic timestamp.
    mem4 = '{8'h59, 8'h30, 8'h12, 8'h31, 8'h12, 8'h16};
    start_and_wait(1'b0, k);
    expect_frame(4, k, mem4);
    cmp_events("directed T4", 1'b0);
    chk("address count", 64'(aq4.size()), 64'd6);
    for (int i = 0; i < 6 && i < aq4.size(); i++)
      chk($sformatf("address %0d", i), 64'(aq4[i]), 64'(8'h21 + i));
    chk("busy rise cycle", 64'(rise4.size() > 0 ? rise4[0] : -1), 64'(k));
    chk("busy fall cycle", 64'(fall4.size() > 0 ? fall4[0] : -1), 64'(k + 78));

    // start held high through two frames: back-to-back, no mid-frame restart.
    for (int i = 0; i < 6; i++) mem4[i] = rnd_byte();
    rise4.delete(); fall4.delete(); q4.delete();
    @(negedge clk);
    b4.start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    while (cyc < k + 100) @(negedge clk);
    b4.start = 1'b0;
    for (int n = 0; n < 300 && fall4.size() < 2; n++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("held start frames", 64'(rise4.size()), 64'd2);
    chk("frame1 end", 64'(fall4.size() > 0 ? fall4[0] : -1), 64'(k + 78));
    chk("frame2 start after busy low", 64'(rise4.size() > 1 ? rise4[1] : -1),
        64'(fall4.size() > 0 ? fall4[0] + 1 : -2));
    k2 = k + 79;
    expect_frame(4, k, mem4);
    expect_frame(4, k2, mem4);
    cmp_events("held start", 1'b0);

    // Bad year byte: suppressed with the BCD check, delivered without it.
    mem4 = '{8'h07, 8'h45, 8'h23, 8'h28, 8'h02, 8'h1A};
    start_and_wait(1'b0, k);
    expect_frame(4, k, mem4);
    cmp_events("bad year", 1'b0);

    // Randomized frames.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 6; i++) mem4[i] = rnd_byte();
      start_and_wait(1'b0, k);
      expect_frame(4, k, mem4);
      cmp_events($sformatf("random T4 #%0d", r), 1'b0);
    end

    // Reset during the third field's READ abandons the frame.
    for (int i = 0; i < 6; i++) mem4[i] = {4'($urandom_range(1, 9)), 4'($urandom_range(0, 9))};
    @(negedge clk);
    b4.start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    b4.start = 1'b0;
    while (cyc < k + 30) @(negedge clk);
    chk("on field 2 READ", 64'({b4.cs_n, b4.rd_n}), 64'(2'b00));
    rst4 = 1'b1;
    q4.delete();
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    @(negedge clk);
    chk("mid-frame reset outputs", 64'(w_o4), 64'(RST_OUTS));
    chk("mid-frame reset dseg", 64'(b4.dseg), 64'd0);
    repeat (100) @(negedge clk);
    chk("no act after reset", 64'(q4.size()), 64'd0);

    // Shortest phase: 4-cycle fields, 24-cycle frame.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) mem1[i] = rnd_byte();
      start_and_wait(1'b1, k);
      expect_frame(1, k, mem1);
      cmp_events($sformatf("T1 #%0d", r), 1'b1);
    end

    chk("ad_oe with rd_n low", 64'(viol4), 64'd0);
    chk("ad_out stable in ADDR", 64'(unstable4), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rtc_read_sequencer.md
# rtc_read_sequencer

Bus master that periodically reads the six time/date registers of the external RTC over its multiplexed 8-bit address/data bus and presents each byte, one at a time, to the per-field display registers. It sits directly upstream of the field registers. For each field it drives a shared byte `dseg`, a one-hot field enable `en_deco`, and a one-cycle update strobe `act`; a field register loads `dseg` when its `en_deco` bit and `act` are both high.

## Interface
Parameters:
- `T_PH`, default 4: cycles per bus phase (address, read, recovery); legal range 1..15.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high; one clock.
- `start`  in  1: request a full read frame; sampled only in IDLE.
- `ad_in`  in  8: RTC A/D bus, input side.
- `ad_out`  out  8: RTC A/D bus, drive side. Carries the address during the ADDR phase, otherwise 0.
- `ad_oe`  out  1: bus output enable; 1 only in ADDR.
- `cs_n`, `rd_n`  out  1 each: chip select and read strobe, active-low.
- `ale`  out  1: address latch enable, active-high.
- `dseg`  out  8: last byte captured from the RTC.
- `en_deco`  out  6: one-hot field select. Bit 0 = seconds, 1 = minutes, 2 = hours, 3 = date, 4 = month, 5 = year.
- `act`  out  1: one-cycle strobe; `dseg`/`en_deco` are valid while it is high.
- `busy`  out  1: frame in progress.
- `done`  out  1: one-cycle pulse, coincident with the final `act` of a frame.
- `bcd_err`  out  1: one-cycle pulse; present only with the macro (see Configuration).

## Operation
- States: IDLE, ADDR, READ, RECOV, LATCH. A 3-bit field index `idx` counts 0..5. A phase counter counts 0..T_PH-1.
- IDLE
  - Bus outputs: `cs_n` = `rd_n` = 1, `ale` = 0, `ad_oe` = 0, `ad_out` = 0.
  - `start` = 1 sets `idx` to 0 and moves to ADDR.
- ADDR (T_PH cycles)
  - `cs_n` = 0, `ale` = 1, `ad_oe` = 1, `ad_out` = `ADDR_TABLE[idx]`.
- READ (T_PH cycles)
  - `cs_n` = 0, `rd_n` = 0, `ale` = 0, `ad_oe` = 0.
  - `dseg` <= `ad_in` at the clock edge that ends the last READ cycle.
- RECOV (T_PH cycles)
  - All bus strobes are deasserted.
- LATCH (1 cycle)
  - `act` = 1 and `en_deco` = (1 << idx). If `idx` = 5, `done` = 1 as well.
  - Next state: ADDR with `idx` + 1, or IDLE after `idx` = 5.
- Outside LATCH, `en_deco` = 0 and `act` = 0.
- `dseg` holds its value between captures.
- `busy` = 1 in every state except IDLE.
- `start` is ignored while `busy` is high. It is not queued.
- Reset values: state IDLE, `idx` 0, `dseg` 0, `en_deco` 0, `act` 0, `done` 0, `bcd_err` 0, `cs_n` 1, `rd_n` 1, `ale` 0, `ad_oe` 0, `ad_out` 0.
- Reset mid-frame: the frame is abandoned. Bus lines are released on the next edge and no further `act` is issued.
- Reset has priority over `start` in the same cycle.

## Timing
- Per field: 3·T_PH + 1 cycles. Per frame: 6·(3·T_PH + 1), which is 78 cycles at T_PH = 4.
- If `start` is seen at edge k, ADDR for seconds begins in cycle k+1. The first `act` occurs in cycle k + 3·T_PH + 1.
- `done` and the last `act` fall in the same cycle. `busy` drops in the following cycle, and a new `start` is accepted from that cycle on.
- `ad_out` is stable during the whole of ADDR. `ad_oe` is never 1 while `rd_n` = 0.

## Configuration
- `RTC_SEQ_BCD_CHECK_EN` defined:
  - In LATCH, if either nibble of `dseg` is greater than 9, then `act` = 0, `en_deco` = 0 and `bcd_err` = 1 for that cycle. The downstream field keeps its old value.
  - The sequence continues to the next field. `done` still pulses on field 5, even if that field was suppressed.
- Macro undefined: `bcd_err` is tied 0 and every captured byte is delivered.

## Structure
- Package `rtc_pkg` holds:
  - the state enum;
  - `N_FIELDS` = 6;
  - `ADDR_TABLE` = {0x21, 0x22, 0x23, 0x24, 0x25, 0x26};
  - field index constants `F_SEC` .. `F_YEAR`.
- One sub-module, `rtc_bus_phase_timer`: loadable down-counter producing a `phase_last` flag, sized by `T_PH`.

## Test plan
- Reset, then `start` with T_PH = 4 and the bus model returning 0x59, 0x30, 0x12, 0x31, 0x12, 0x16 → six `act` pulses:
  - spaced 13 cycles apart;
  - `en_deco` = 0x01, 0x02, 0x04, 0x08, 0x10, 0x20 in turn;
  - `dseg` matching each byte;
  - `done` with the 6th pulse.
- Bus protocol check → `ad_out` = 0x21..0x26 in order while `ale` = 1; `ad_oe` & ~`rd_n` never true.
- `start` held high during a frame → no restart. Frames run back-to-back, and each frame's first ADDR begins in the cycle after `busy` falls.
- Reset asserted on the 3rd field's READ → the next cycle shows all outputs at reset values, `dseg` = 0, and no further `act`.
- With the macro, the year byte read as 0x1A → no `act` on field 5, `bcd_err` = 1 and `done` = 1 in that cycle. Without the macro → `act` with `dseg` = 0x1A.
- T_PH = 1 → 4-cycle field spacing, 24-cycle frame.
